// File: rtl/coin_credit_manager.sv
// rtl/coin_credit_manager.sv - coin/select/refund buttons to running credit, vend and change sequencing
// Optional idle auto-refund: define VENDING_TIMEOUT_EN.
`timescale 1ns/1ps
module coin_credit_manager #(
  parameter int MAX_CREDIT  = 99,
  parameter int PRICE0      = 5,
  parameter int PRICE1      = 8,
  parameter int PRICE2      = 12,
  parameter int PRICE3      = 15,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_100,
  input  logic       coin_500,
  input  logic       coin_1000,
  input  logic [3:0] sel,
  input  logic       refund,
  output logic [7:0] display_money_binary,
  output logic       vend,
  output logic [1:0] vend_item,
  output logic       change_pulse,
  output logic       reject,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE_HI, CHANGE_LO} state_t;

  localparam logic [8:0] MAX_SUM = 9'(MAX_CREDIT);

  state_t     state, state_next;
  logic [7:0] credit, credit_next;
  logic [1:0] item_next;
  logic       reject_next;

  // Button bits: {refund, sel[3:0], coin_1000, coin_500, coin_100}
  logic [7:0] raw, sync1, sync2, prev, evt;

  assign raw = {refund, sel, coin_1000, coin_500, coin_100};
  assign evt = sync2 & ~prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 8'd0;
      sync2 <= 8'd0;
      prev  <= 8'd0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  logic [3:0] coin_val;
  logic [1:0] sel_idx;
  logic [7:0] sel_price;
  logic [8:0] coin_sum;
  logic       sel_any;

  always_comb begin
    coin_val = 4'd0;
    if (evt[2])      coin_val = 4'd10;
    else if (evt[1]) coin_val = 4'd5;
    else if (evt[0]) coin_val = 4'd1;

    sel_idx = 2'd0;
    if (evt[3])      sel_idx = 2'd0;
    else if (evt[4]) sel_idx = 2'd1;
    else if (evt[5]) sel_idx = 2'd2;
    else if (evt[6]) sel_idx = 2'd3;

    case (sel_idx)
      2'd0:    sel_price = 8'(PRICE0);
      2'd1:    sel_price = 8'(PRICE1);
      2'd2:    sel_price = 8'(PRICE2);
      default: sel_price = 8'(PRICE3);
    endcase
  end

  assign coin_sum = {1'b0, credit} + {5'd0, coin_val};
  assign sel_any  = |evt[6:3];

`ifdef VENDING_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] idle_cnt, idle_cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt <= '0;
    else      idle_cnt <= idle_cnt_next;
  end
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYC[0];
`endif

  always_comb begin
    state_next  = state;
    credit_next = credit;
    item_next   = vend_item;
    reject_next = 1'b0;
`ifdef VENDING_TIMEOUT_EN
    idle_cnt_next = '0;
`endif
    case (state)
      IDLE: begin
        // Only the highest-priority event class is acted on; the rest are dropped.
        if (evt[7]) begin
          if (credit != 8'd0) state_next = CHANGE_HI;
        end else if (sel_any) begin
          if (credit >= sel_price) begin
            credit_next = credit - sel_price;
            item_next   = sel_idx;
            state_next  = VEND;
          end else begin
            reject_next = 1'b1;
          end
        end else if (coin_val != 4'd0) begin
          if (coin_sum <= MAX_SUM) credit_next = coin_sum[7:0];
          else                     reject_next = 1'b1;
        end
`ifdef VENDING_TIMEOUT_EN
        if (evt == 8'd0 && credit != 8'd0) begin
          if (idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) state_next = CHANGE_HI;
          else                                     idle_cnt_next = idle_cnt + 1'b1;
        end
`endif
      end
      VEND:      state_next = IDLE;
      CHANGE_HI: begin
        credit_next = credit - 8'd1;
        state_next  = CHANGE_LO;
      end
      CHANGE_LO: state_next = (credit == 8'd0) ? IDLE : CHANGE_HI;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      credit    <= 8'd0;
      vend_item <= 2'd0;
      reject    <= 1'b0;
    end else begin
      state     <= state_next;
      credit    <= credit_next;
      vend_item <= item_next;
      reject    <= reject_next;
    end
  end

  assign display_money_binary = credit;
  assign vend                 = (state == VEND);
  assign change_pulse         = (state == CHANGE_HI);
  assign busy                 = (state != IDLE);

endmodule

// File: doc/coin_credit_manager.md
# coin_credit_manager

Upstream stage of the money display path. Converts push-button coin inserts, product selections and refund requests into a running credit value, sequences vend and change-return events with a small FSM, and drives the 8-bit binary credit consumed by the FND display driver. Credit is counted in 100-won units; the display appends the two fixed trailing zeros.

## Interface
- MAX_CREDIT, 99, credit ceiling in 100-won units (two displayable digits)
- PRICE0, 5, price of item 0 (units)
- PRICE1, 8, price of item 1
- PRICE2, 12, price of item 2
- PRICE3, 15, price of item 3
- TIMEOUT_CYC, 1000, idle cycles before auto-refund (used only with VENDING_TIMEOUT_EN)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- coin_100  in  1  raw button level, 1-unit coin
- coin_500  in  1  raw button level, 5-unit coin
- coin_1000  in  1  raw button level, 10-unit note
- sel  in  4  raw button levels, product select, bit k = item k
- refund  in  1  raw button level, return all credit
- display_money_binary  out  8  current credit, units of 100 won
- vend  out  1  one-cycle pulse, item dispensed
- vend_item  out  2  index of dispensed item, valid while vend=1
- change_pulse  out  1  one pulse per unit returned
- reject  out  1  one-cycle pulse, coin or selection refused
- busy  out  1  high in VEND/CHANGE states

## Operation
- All 8 button inputs: two-flop synchronizer, then rising-edge detect; one event per press regardless of hold length.
- States: IDLE, VEND, CHANGE_HI, CHANGE_LO.
- IDLE event priority in one cycle: refund > sel > coin. Among coins: 1000 > 500 > 100; lower-priority simultaneous edges dropped. Among sel bits: lowest index wins.
- Coin: if credit + value <= MAX_CREDIT, credit += value; else credit unchanged, reject pulse.
- Select k: if credit >= PRICEk, credit -= PRICEk, vend_item <= k, go VEND; else reject pulse, stay IDLE.
- VEND: vend=1 for exactly one cycle, return to IDLE.
- Refund with credit > 0: go CHANGE_HI. Credit 0: no-op, no reject.
- CHANGE_HI: change_pulse=1, credit -= 1, go CHANGE_LO. CHANGE_LO: change_pulse=0; credit 0 -> IDLE, else CHANGE_HI. N units -> N pulses, 50% duty, period 2 cycles.
- Edges arriving while busy are discarded, not queued.
- Credit arithmetic in 8 bits; never exceeds MAX_CREDIT, never underflows.
- display_money_binary is the credit register directly (no extra stage).

## Timing
- Reset values: display_money_binary=0, vend=0, vend_item=0, change_pulse=0, reject=0, busy=0, state IDLE, synchronizer/edge flops 0.
- Input latency: input high before clock edge 1 -> synchronized at edge 2 -> edge detected and credit/state updated at edge 3.
- vend asserted the cycle after the select is accepted; credit already decremented when vend rises.
- busy=1 from VEND entry until return to IDLE; refund of N units keeps busy for 2N cycles.
- Reset mid-refund: credit cleared immediately, remaining change pulses lost.

## Configuration
- VENDING_TIMEOUT_EN defined: idle counter clears on any accepted or rejected event and whenever credit=0; in IDLE with credit>0 and counter = TIMEOUT_CYC-1, enters CHANGE_HI exactly as a refund.
- Not defined: no counter, credit held indefinitely; TIMEOUT_CYC unused.

## Test plan
- Reset, press coin_500 twice, coin_100 once -> display_money_binary 5, 10, 11; no reject.
- Credit 95, press coin_1000 -> reject one cycle, credit stays 95; coin_100 -> 96.
- Credit 11, sel=4'b0100 (PRICE2=12) -> reject, credit 11; sel=4'b0010 -> vend pulse, vend_item=1, credit 3.
- Credit 3, refund -> exactly 3 change_pulse at cycles t, t+2, t+4; credit 2,1,0; busy low after 6 cycles; coin press during refund ignored.
- Same-cycle refund+sel+coin_100 with credit 8 -> refund wins, 8 change pulses, no vend.
- VENDING_TIMEOUT_EN, TIMEOUT_CYC=20, credit 2, no input -> change sequence starts after 20 idle cycles; without macro credit stays 2 for 100 cycles.
